inference_sequencer: RTL and testbench
======================================

Name: inference_sequencer

Overview:
- Top-level inference controller that drives the SRAM staging buffer's read-side request lines (get_weights, get_inputs, get_out).
- Fetches NUM_WEIGHTS weight words, then num_inputs input words, and forwards each word to the MAC array with a valid/ready handshake.
- Then requests output collection and reports completion or error to the AHB subordinate.
- Owns all sequencing; the buffer only services one request at a time.

Parameters:
NUM_WEIGHTS, 8, weight words loaded per inference (1..8)
TIMEOUT_CYCLES, 1023, watchdog limit in cycles per outstanding request (used only with the optional feature)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from AHB: begin inference
num_inputs  in  8  input-word count from buffer; sampled on accepted start
data_ready  in  1  buffer read data valid; held high until buffer returns to idle
data  in  64  buffer read data
out_done  in  1  one-cycle pulse: buffer finished output collection
occupancy_err  in  1  one-cycle pulse: buffer over/underflow
array_ready  in  1  MAC array can accept a word
get_weights  out  1  one-cycle request pulse to buffer
get_inputs  out  1  one-cycle request pulse to buffer
get_out  out  1  one-cycle request pulse to buffer
word_valid  out  1  word presented to MAC array
word_is_weight  out  1  1 = weight word, 0 = input word
weight_row  out  3  weight row index of presented weight word
word_data  out  64  registered word to MAC array
busy  out  1  high from accepted start until DONE/ERROR
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag; cleared by next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; latched count 0.
- States: IDLE, REQ_W, WAIT_W, PUSH_W, DRAIN_W, REQ_I, WAIT_I, PUSH_I, DRAIN_I, REQ_OUT, WAIT_OUT, DONE, ERROR.
- IDLE:
  - start=1 and num_inputs!=0: latch n_in=num_inputs, clear err, set busy, go REQ_W.
  - start=1 and num_inputs==0: set err, go ERROR.
  - start is ignored in every state except IDLE and ERROR.
- Weight phase:
  - REQ_W: get_weights=1 for exactly one cycle, go WAIT_W.
  - WAIT_W: on first cycle with data_ready=1, capture data into word_data, go PUSH_W.
  - PUSH_W: word_valid=1, word_is_weight=1, weight_row=w_cnt. Hold until array_ready=1; the handshake completes in that cycle. Then w_cnt++ and go DRAIN_W.
  - DRAIN_W: wait for data_ready=0. Then go REQ_W if w_cnt<NUM_WEIGHTS, else go REQ_I.
  - Never issue a new get_* while data_ready=1.
- Input phase: REQ_I / WAIT_I / PUSH_I / DRAIN_I mirror the weight phase, with these differences:
  - get_inputs instead of get_weights.
  - word_is_weight=0; weight_row is don't-care, driven 0.
  - i_cnt counts to n_in; after the last input, DRAIN_I goes to REQ_OUT.
- Latency: request pulse to word_valid is at least 2 cycles (data_ready sampled, word_data registered).
- Output phase:
  - REQ_OUT: get_out one cycle, go WAIT_OUT.
  - WAIT_OUT: wait for out_done=1, go DONE.
- DONE: done=1 for one cycle, busy=0, go IDLE.
- ERROR:
  - busy=0, err=1, all request and valid outputs 0.
  - start=1 with num_inputs!=0 restarts exactly as from IDLE (err cleared).
- occupancy_err=1 in any state other than IDLE/DONE/ERROR:
  - Immediate transition to ERROR, err=1.
  - Takes priority over every other transition in the same cycle, including data_ready capture and out_done.
- Counters:
  - w_cnt is 4 bits, i_cnt is 8 bits.
  - Comparisons are unsigned; n_in=255 is legal; i_cnt never wraps.
- Simultaneous events:
  - data_ready rising in the same cycle the request pulse is issued is not expected; it is sampled only in WAIT_*.
  - out_done arriving before WAIT_OUT is ignored.
- Reset mid-operation returns to reset values immediately; there is no partial-inference resume.

Optional Feature:
INFERENCE_WATCHDOG_EN
- Defined:
  - A 10-bit watchdog counter clears on entry to each of WAIT_W, WAIT_I, PUSH_W, PUSH_I, WAIT_OUT and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES forces ERROR with err=1.
- Undefined:
  - No counter is present; the FSM waits indefinitely in those states.

Test Plan:
1. Reset, then start with num_inputs=3; buffer model returns data_ready after 4 cycles, array_ready always 1 -> 8 get_weights pulses with weight_row 0..7, 3 get_inputs pulses, 1 get_out, then done pulse; busy high throughout.
2. Weight word 0xDEAD_BEEF_0123_4567 with array_ready low for 5 cycles -> word_valid and word_data held stable for all 5 cycles; w_cnt advances only on the handshake cycle.
3. start with num_inputs=0 -> err=1, busy=0, no get_* pulses. Then start with num_inputs=1 -> err clears and the normal sequence runs.
4. occupancy_err pulse during WAIT_I at i_cnt=2, same cycle as data_ready=1 -> ERROR, word not captured, no further get_* pulses, err sticky.
5. n_rst asserted during PUSH_I -> all outputs 0 asynchronously. After release, start runs a full clean sequence from weight row 0.
6. With INFERENCE_WATCHDOG_EN and TIMEOUT_CYCLES=16, data_ready never asserted after the first get_weights -> ERROR entered exactly 16 cycles after entry to WAIT_W.

Source files
------------

// File: rtl/inference_sequencer.sv
// inference_sequencer: fetches weight then input words from the staging buffer, hands them to the MAC array, then collects output.
// Define INFERENCE_WATCHDOG_EN to add a per-request timeout watchdog that forces ERROR.
module inference_sequencer #(
  parameter int NUM_WEIGHTS = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [7:0]  num_inputs,
  input  logic        data_ready,
  input  logic [63:0] data,
  input  logic        out_done,
  input  logic        occupancy_err,
  input  logic        array_ready,
  output logic        get_weights,
  output logic        get_inputs,
  output logic        get_out,
  output logic        word_valid,
  output logic        word_is_weight,
  output logic [2:0]  weight_row,
  output logic [63:0] word_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {
    IDLE, REQ_W, WAIT_W, PUSH_W, DRAIN_W, REQ_I, WAIT_I, PUSH_I, DRAIN_I,
    REQ_OUT, WAIT_OUT, DONE, ERROR
  } state_t;
  state_t state, nxt;
  logic [3:0] w_cnt;
  logic [7:0] i_cnt, n_in;
  logic active, accept, timeout;
  if (NUM_WEIGHTS < 1 || NUM_WEIGHTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_param
    $error("inference_sequencer: NUM_WEIGHTS must be 1..8 and TIMEOUT_CYCLES 1..1023");
  end
  assign active = !(state inside {IDLE, DONE, ERROR});
  assign accept = (state == IDLE || state == ERROR) && start && num_inputs != 8'd0;
`ifdef INFERENCE_WATCHDOG_EN
  logic [9:0] wd;
  logic watched;
  assign watched = state inside {WAIT_W, WAIT_I, PUSH_W, PUSH_I, WAIT_OUT};
  assign timeout = watched && wd == 10'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  // Occupancy faults and timeouts outrank every other transition, including data capture.
  always_comb begin
    nxt = state;
    if (active && (occupancy_err || timeout)) nxt = ERROR;
    else
      case (state)
        IDLE, ERROR: if (start) nxt = num_inputs != 8'd0 ? REQ_W : ERROR;
        REQ_W:    nxt = WAIT_W;
        WAIT_W:   if (data_ready) nxt = PUSH_W;
        PUSH_W:   if (array_ready) nxt = DRAIN_W;
        DRAIN_W:  if (!data_ready) nxt = w_cnt < 4'(NUM_WEIGHTS) ? REQ_W : REQ_I;
        REQ_I:    nxt = WAIT_I;
        WAIT_I:   if (data_ready) nxt = PUSH_I;
        PUSH_I:   if (array_ready) nxt = DRAIN_I;
        DRAIN_I:  if (!data_ready) nxt = i_cnt < n_in ? REQ_I : REQ_OUT;
        REQ_OUT:  nxt = WAIT_OUT;
        WAIT_OUT: if (out_done) nxt = DONE;
        default:  nxt = IDLE;
      endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      w_cnt          <= '0;
      i_cnt          <= '0;
      n_in           <= '0;
      get_weights    <= 1'b0;
      get_inputs     <= 1'b0;
      get_out        <= 1'b0;
      word_valid     <= 1'b0;
      word_is_weight <= 1'b0;
      weight_row     <= '0;
      word_data      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef INFERENCE_WATCHDOG_EN
      wd             <= '0;
`endif
    end else begin
      state          <= nxt;
      get_weights    <= nxt == REQ_W;
      get_inputs     <= nxt == REQ_I;
      get_out        <= nxt == REQ_OUT;
      word_valid     <= nxt == PUSH_W || nxt == PUSH_I;
      word_is_weight <= nxt == PUSH_W;
      weight_row     <= nxt == PUSH_W ? w_cnt[2:0] : 3'd0;
      busy           <= !(nxt inside {IDLE, DONE, ERROR});
      done           <= nxt == DONE;
      err            <= nxt == ERROR;
      if (accept) begin
        n_in  <= num_inputs;
        w_cnt <= '0;
        i_cnt <= '0;
      end
      if (state == PUSH_W && nxt == DRAIN_W) w_cnt <= w_cnt + 4'd1;
      if (state == PUSH_I && nxt == DRAIN_I) i_cnt <= i_cnt + 8'd1;
      if ((state == WAIT_W && nxt == PUSH_W) || (state == WAIT_I && nxt == PUSH_I)) word_data <= data;
`ifdef INFERENCE_WATCHDOG_EN
      wd <= (nxt != state || !watched) ? '0 : wd + 10'd1;
`endif
    end
  end
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: directed bench with a buffer model feeding a scoreboard of expected MAC-array words.
module tb_inference_sequencer;
  localparam int NW = 8;
  localparam logic [63:0] W_BASE = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] I_BASE = 64'h5A5A_0000_0000_1000;
  logic clk = 0, n_rst, start, data_ready, out_done, occupancy_err, array_ready;
  logic [7:0] num_inputs;
  logic [63:0] data, word_data;
  logic get_weights, get_inputs, get_out, word_valid, word_is_weight, busy, done, err;
  logic [2:0] weight_row;
  logic [10:0] outs;
  typedef struct { logic w; logic [2:0] row; logic [63:0] d; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int req_w, req_i, req_o, w_served, i_served;
  int occ_idx = -1;
  logic buf_en = 1'b1;

  inference_sequencer #(.NUM_WEIGHTS(NW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .num_inputs(num_inputs),
    .data_ready(data_ready), .data(data), .out_done(out_done),
    .occupancy_err(occupancy_err), .array_ready(array_ready),
    .get_weights(get_weights), .get_inputs(get_inputs), .get_out(get_out),
    .word_valid(word_valid), .word_is_weight(word_is_weight),
    .weight_row(weight_row), .word_data(word_data), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign outs = {get_weights, get_inputs, get_out, word_valid, word_is_weight, weight_row, busy, done, err};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Buffer model: answers each request after 4 cycles and queues the word the array should see.
  initial begin
    data_ready = 0; data = '0; out_done = 0; occupancy_err = 0;
    forever begin
      @(negedge clk);
      if (buf_en && (get_weights || get_inputs)) begin
        automatic logic is_w = get_weights;
        repeat (4) @(negedge clk);
        if (is_w) begin
          data = W_BASE + 64'(w_served);
          q.push_back('{1'b1, 3'(w_served), data});
          w_served++;
        end else begin
          data = I_BASE + 64'(i_served);
          if (i_served == occ_idx) occupancy_err = 1;
          else q.push_back('{1'b0, 3'd0, data});
          i_served++;
        end
        data_ready = 1;
        @(negedge clk);
        occupancy_err = 0;
        repeat (2) @(negedge clk);
        data_ready = 0;
      end else if (buf_en && get_out) begin
        repeat (3) @(negedge clk);
        out_done = 1;
        @(negedge clk);
        out_done = 0;
      end
    end
  end

  // Monitor: counts request pulses and pops the scoreboard on every handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (get_weights) req_w++;
    if (get_inputs) req_i++;
    if (get_out) req_o++;
    if (get_weights || get_inputs || get_out) chk("get_while_ready", data_ready, 0);
    if (word_valid && array_ready) begin
      if (q.size() == 0) chk("unexpected_word", word_valid, 0);
      else begin
        automatic exp_t e = q.pop_front();
        chk("word_data", word_data, e.d);
        chk("word_is_weight", word_is_weight, e.w);
        chk("weight_row", weight_row, e.row);
        chk("busy_in_push", busy, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic begin_run();
    req_w = 0; req_i = 0; req_o = 0; w_served = 0; i_served = 0;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1; num_inputs = 8'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic end_run(input int n);
    int c = 0;
    logic got = 0, dropped = 0;
    while (c < 6000 && !got) begin
      @(negedge clk);
      got = done;
      if (!done && !busy) dropped = 1;
      c++;
    end
    chk("done_seen", got, 1);
    chk("busy_held", dropped, 0);
    chk("busy_at_done", busy, 0);
    chk("get_weights_count", req_w, NW);
    chk("get_inputs_count", req_i, n);
    chk("get_out_count", req_o, 1);
    chk("scoreboard_empty", q.size(), 0);
    @(negedge clk);
    chk("idle_after_done", outs, 0);
  endtask

  initial begin
    int c;
    n_rst = 0; start = 0; num_inputs = 0; array_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    chk("reset_word_data", word_data, 0);
    n_rst = 1;
    @(negedge clk);
    chk("idle_outs", outs, 0);
    // Full inference, three inputs
    begin_run();
    do_start(3);
    end_run(3);
    // Stalled handshake on weight word 0
    begin_run();
    array_ready = 0;
    do_start(2);
    c = 0;
    while (c < 20 && !word_valid) begin @(negedge clk); c++; end
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", word_valid, 1);
      chk("stall_data", word_data, W_BASE);
      chk("stall_row", weight_row, 0);
      @(negedge clk);
    end
    array_ready = 1;
    end_run(2);
    // Zero input count is an error; a valid start recovers
    begin_run();
    do_start(0);
    @(negedge clk);
    chk("zero_err", err, 1);
    chk("zero_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("zero_no_requests", req_w + req_i + req_o, 0);
    begin_run();
    do_start(1);
    chk("err_cleared", err, 0);
    end_run(1);
    // Occupancy fault coincident with input word 2 arriving
    begin_run();
    occ_idx = 2;
    do_start(4);
    c = 0;
    while (c < 400 && !err) begin @(negedge clk); c++; end
    chk("occ_err", err, 1);
    repeat (20) @(negedge clk);
    occ_idx = -1;
    chk("occ_err_sticky", err, 1);
    chk("occ_busy", busy, 0);
    chk("occ_word_valid", word_valid, 0);
    chk("occ_not_captured", word_data, I_BASE + 64'd1);
    chk("occ_weights", req_w, NW);
    chk("occ_inputs", req_i, 3);
    chk("occ_no_out", req_o, 0);
    chk("occ_scoreboard", q.size(), 0);
    // Asynchronous reset during an input push, then clean restart
    begin_run();
    do_start(2);
    c = 0;
    while (c < 400 && !(word_valid && !word_is_weight)) begin @(negedge clk); c++; end
    array_ready = 0;
    chk("push_i_reached", word_valid && !word_is_weight, 1);
    @(negedge clk);
    #1 n_rst = 0;
    #1;
    chk("async_reset_outs", outs, 0);
    chk("async_reset_data", word_data, 0);
    repeat (3) @(negedge clk);
    n_rst = 1;
    repeat (8) @(negedge clk);
    q.delete();
    array_ready = 1;
    begin_run();
    do_start(2);
    end_run(2);
    // Largest input count
    begin_run();
    do_start(255);
    end_run(255);
`ifdef INFERENCE_WATCHDOG_EN
    // Buffer never answers: watchdog fires 16 cycles after entering WAIT_W
    begin_run();
    buf_en = 0;
    do_start(1);
    c = 0;
    while (c < 10 && !get_weights) begin @(negedge clk); c++; end
    c = 0;
    while (c < 40 && !err) begin @(negedge clk); c++; end
    chk("watchdog_cycles", c, 17);
    chk("watchdog_busy", busy, 0);
    buf_en = 1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
